bht_update_arbiter: RTL and testbench

//  Owns the 2-bit branch history table (BHT): sequences power-up init, queues resolved-branch updates from EX,
//  and arbitrates the table's single read port between IF lookups and update read-modify-writes.

---
 rtl/bht_update_arbiter.sv | 143 ++++++++++++++
 tb/tb_bht_update_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_arbiter.sv
// BHT owner: power-up init sweep, queued EX updates applied as read-modify-write,
// and arbitration of the single RAM read port between IF lookups and updates.
module bht_update_arbiter #(
   parameter int         PC_W     = 8,
   parameter int         IDX_W    = 6,
   parameter int         DEPTH    = 4,
   parameter logic [1:0] INIT_VAL = 2'b01,
   parameter int         STARVE   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch_req,
   input  logic [PC_W-1:0]  fetch_pc,
   output logic             fetch_gnt,
   output logic             fetch_valid,
   output logic             fetch_pred,
   input  logic             upd_valid,
   input  logic [PC_W-1:0]  upd_pc,
   input  logic             upd_taken,
   input  logic             upd_pred,
   output logic             upd_ready,
   output logic             mispredict,
   output logic             tbl_rd_en,
   output logic [IDX_W-1:0] tbl_rd_addr,
   input  logic [1:0]       tbl_rd_data,
   output logic             tbl_wr_en,
   output logic [IDX_W-1:0] tbl_wr_addr,
   output logic [1:0]       tbl_wr_data,
   output logic             init_busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SC_W  = $clog2(STARVE + 1);

   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state_q;
   logic [IDX_W-1:0] sweep_q;
   logic [IDX_W:0]   fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [SC_W-1:0]  starve_q, starve_d;
   logic             wr_en_q;
   logic [IDX_W-1:0] wr_addr_q;
   logic             rmw_q, rmw_taken_q;
   logic             byp_q;
   logic [1:0]       byp_data_q;
   logic             fetch_valid_q, mispredict_q;

   logic             run, fifo_empty, fifo_full, upd_win, push;
   logic [IDX_W:0]   head;
   logic [1:0]       rd_val, sat_val;

   assign run        = (state_q == S_RUN);
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(DEPTH));
   assign head       = fifo_mem[rd_ptr_q];

   // Only one RMW in flight: the head may not read while the previous RMW is writing.
   assign upd_win   = run && !fifo_empty && !rmw_q && (!fetch_req || (starve_q == SC_W'(STARVE)));
   assign fetch_gnt = run && fetch_req && !upd_win;
   assign tbl_rd_en   = upd_win || fetch_gnt;
   assign tbl_rd_addr = upd_win ? head[IDX_W:1] : fetch_pc[IDX_W-1:0];

   assign upd_ready = run && !fifo_full;
   assign push      = upd_valid && upd_ready;

   // RAM returns old data on read-during-write; substitute the value written that cycle.
   assign rd_val = byp_q ? byp_data_q : tbl_rd_data;

   always_comb begin
      sat_val = rd_val;
      if (rmw_taken_q) begin
         if (rd_val != 2'b11) sat_val = rd_val + 2'b01;
      end else begin
         if (rd_val != 2'b00) sat_val = rd_val - 2'b01;
      end
   end

   assign tbl_wr_en   = wr_en_q;
   assign tbl_wr_addr = wr_addr_q;
   assign tbl_wr_data = rmw_q ? sat_val : INIT_VAL;

   assign fetch_valid = fetch_valid_q;
   assign fetch_pred  = fetch_valid_q && rd_val[1];
   assign mispredict  = mispredict_q;
   assign init_busy   = (state_q == S_INIT);

   always_comb begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(upd_win);
      starve_d = starve_q;
      if (upd_win)
         starve_d = '0;
      else if (fifo_full && (starve_q != SC_W'(STARVE)))
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_INIT;
         sweep_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         starve_q      <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         rmw_q         <= 1'b0;
         rmw_taken_q   <= 1'b0;
         byp_q         <= 1'b0;
         byp_data_q    <= 2'b00;
         fetch_valid_q <= 1'b0;
         mispredict_q  <= 1'b0;
      end else begin
         if (state_q == S_INIT) begin
            sweep_q   <= sweep_q + 1'b1;
            wr_en_q   <= 1'b1;
            wr_addr_q <= sweep_q;
            if (sweep_q == {IDX_W{1'b1}}) state_q <= S_RUN;
         end else begin
            wr_en_q   <= upd_win;
            wr_addr_q <= head[IDX_W:1];
         end
         rmw_q         <= upd_win;
         rmw_taken_q   <= head[0];
         byp_q         <= tbl_rd_en && wr_en_q && (wr_addr_q == tbl_rd_addr);
         byp_data_q    <= tbl_wr_data;
         fetch_valid_q <= fetch_gnt;
         mispredict_q  <= push && (upd_taken ^ upd_pred);
         if (push)    wr_ptr_q <= wr_ptr_q + 1'b1;
         if (upd_win) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q  <= count_d;
         starve_q <= starve_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= {upd_pc[IDX_W-1:0], upd_taken};
   end

endmodule

// File: tb/tb_bht_update_arbiter.sv
// Randomized bench for bht_update_arbiter: a 1R1W RAM model plus a queue/table
// reference of the predictor, checked every cycle on the falling edge.
module tb_bht_update_arbiter;
   localparam int PC_W = 8, IDX_W = 6, DEPTH = 4, STARVE = 8, N = 64;

   logic clk = 1'b0, reset = 1'b0;
   logic fetch_req = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0, upd_pred = 1'b0;
   logic [PC_W-1:0] fetch_pc = '0, upd_pc = '0;
   logic fetch_gnt, fetch_valid, fetch_pred, upd_ready, mispredict;
   logic tbl_rd_en, tbl_wr_en, init_busy;
   logic [IDX_W-1:0] tbl_rd_addr, tbl_wr_addr;
   logic [1:0] tbl_rd_data = 2'b00, tbl_wr_data;

   bht_update_arbiter dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_gnt(fetch_gnt),
      .fetch_valid(fetch_valid), .fetch_pred(fetch_pred),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
      .upd_ready(upd_ready), .mispredict(mispredict),
      .tbl_rd_en(tbl_rd_en), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data),
      .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
      .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   // 1R1W synchronous RAM, old data on read-during-write; starts as garbage (11).
   logic [1:0] mem [N];
   initial for (int i = 0; i < N; i++) mem[i] = 2'b11;
   always @(posedge clk) begin
      if (tbl_rd_en) tbl_rd_data <= mem[tbl_rd_addr];
      if (tbl_wr_en) mem[tbl_wr_addr] <= tbl_wr_data;
   end

   int total = 0, bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] sat2(input logic [1:0] c, input logic t);
      int v;
      v = int'(c) + (t ? 1 : -1);
      if (v > 3) v = 3;
      if (v < 0) v = 0;
      return 2'(v);
   endfunction

   typedef struct packed { logic [IDX_W-1:0] idx; logic taken; } upd_t;

   // Reference state
   int         cyc;
   logic [1:0] mtbl [N];
   upd_t       mq [$];
   upd_t       rmw_e, e;
   bit         rmw_m, fv_m, fp_m, mis_m, run_m, win_m, gnt_m, rdy_m, full_m;
   int         starve_m;
   bit         gnt_seen, acc_seen;

   always @(negedge clk) begin
      if (!reset) begin
         cyc = 0; mq.delete(); rmw_m = 0; starve_m = 0;
         fv_m = 0; fp_m = 0; mis_m = 0; gnt_seen = 0; acc_seen = 0;
      end else begin
         run_m = (cyc >= N);
         // Write port: pending RMW result, else the init sweep, else idle
         if (rmw_m) begin
            mtbl[rmw_e.idx] = sat2(mtbl[rmw_e.idx], rmw_e.taken);
            check("rmw_wr_en", 32'(tbl_wr_en), 32'd1);
            check("rmw_wr_addr", 32'(tbl_wr_addr), 32'(rmw_e.idx));
            check("rmw_wr_data", 32'(tbl_wr_data), 32'(mtbl[rmw_e.idx]));
         end else if (cyc >= 1 && cyc <= N) begin
            mtbl[cyc-1] = 2'b01;
            check("init_wr_en", 32'(tbl_wr_en), 32'd1);
            check("init_wr_addr", 32'(tbl_wr_addr), 32'(cyc-1));
            check("init_wr_data", 32'(tbl_wr_data), 32'd1);
         end else begin
            check("idle_wr_en", 32'(tbl_wr_en), 32'd0);
         end
         check("init_busy", 32'(init_busy), 32'(!run_m));
         check("fetch_valid", 32'(fetch_valid), 32'(fv_m));
         check("fetch_pred", 32'(fetch_pred), 32'(fv_m & fp_m));
         check("mispredict", 32'(mispredict), 32'(mis_m));

         full_m = (mq.size() == DEPTH);
         win_m  = run_m && (mq.size() > 0) && !rmw_m && (!fetch_req || starve_m >= STARVE);
         gnt_m  = run_m && fetch_req && !win_m;
         rdy_m  = run_m && (mq.size() < DEPTH);
         check("fetch_gnt", 32'(fetch_gnt), 32'(gnt_m));
         check("rd_en", 32'(tbl_rd_en), 32'(win_m || gnt_m));
         check("upd_ready", 32'(upd_ready), 32'(rdy_m));
         if (win_m) check("upd_rd_addr", 32'(tbl_rd_addr), 32'(mq[0].idx));
         else if (gnt_m) check("fetch_rd_addr", 32'(tbl_rd_addr), 32'(fetch_pc[IDX_W-1:0]));

         fv_m  = gnt_m;
         fp_m  = gnt_m ? mtbl[fetch_pc[IDX_W-1:0]][1] : 1'b0;
         mis_m = upd_valid && rdy_m && (upd_taken != upd_pred);
         if (win_m) begin
            rmw_e = mq.pop_front(); rmw_m = 1; starve_m = 0;
         end else begin
            rmw_m = 0;
            if (full_m && starve_m < STARVE) starve_m++;
         end
         if (upd_valid && rdy_m) begin
            e.idx = upd_pc[IDX_W-1:0]; e.taken = upd_taken;
            mq.push_back(e);
         end
         gnt_seen = fetch_gnt;
         acc_seen = upd_valid && upd_ready;
         cyc++;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_fetch(input logic [PC_W-1:0] pc);
      int n = 0;
      fetch_req = 1'b1; fetch_pc = pc;
      do begin step(); n++; end while (!gnt_seen && n < 200);
      if (!gnt_seen) check("fetch_timeout", 32'd0, 32'd1);
      fetch_req = 1'b0;
   endtask

   task automatic do_upd(input logic [PC_W-1:0] pc, input logic t, input logic p);
      int n = 0;
      upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_pred = p;
      do begin step(); n++; end while (!acc_seen && n < 200);
      if (!acc_seen) check("upd_timeout", 32'd0, 32'd1);
      upd_valid = 1'b0;
   endtask

   task automatic rand_cycles(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         step();
         if (!fetch_req || gnt_seen) begin
            fetch_req = 1'($urandom_range(0, 1));
            fetch_pc  = 8'($urandom);
         end
         upd_valid = 1'($urandom_range(0, 1));
         upd_pc    = 8'($urandom) & 8'hC7;
         upd_taken = 1'($urandom);
         upd_pred  = 1'($urandom);
      end
      step();
      fetch_req = 1'b0; upd_valid = 1'b0;
   endtask

   initial begin
      int acc;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (N + 2) step();
      do_fetch(8'h05);
      repeat (2) step();
      for (int i = 0; i < 3; i++) do_upd(8'h05, 1'b1, 1'b1);
      repeat (4) step();
      do_fetch(8'h45);
      // Fetch lands in the write cycle of the pc=3 RMW to exercise the bypass
      do_upd(8'h03, 1'b1, 1'b0);
      step();
      do_fetch(8'h03);
      repeat (2) step();
      do_upd(8'h09, 1'b1, 1'b0);
      do_upd(8'h09, 1'b0, 1'b0);
      repeat (3) step();
      // Starvation: fetch never lets go while updates pile up
      for (int i = 0; i < 40; i++) begin
         fetch_req = 1'b1;
         if (gnt_seen) fetch_pc = 8'($urandom);
         upd_valid = 1'b1; upd_pc = 8'($urandom) & 8'h07; upd_taken = 1'($urandom); upd_pred = 1'($urandom);
         step();
      end
      fetch_req = 1'b0; upd_valid = 1'b0;
      repeat (10) step();
      rand_cycles(3000);
      repeat (5) step();
      // Reset in the middle of queued updates
      acc = 0;
      upd_valid = 1'b1; upd_pc = 8'h11; upd_taken = 1'b1;
      for (int i = 0; i < 40 && acc < 4; i++) begin
         step();
         if (acc_seen) acc++;
      end
      check("mid_reset_fill", 32'(acc), 32'd4);
      upd_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("rst_wr_en", 32'(tbl_wr_en), 32'd0);
      check("rst_init_busy", 32'(init_busy), 32'd1);
      check("rst_upd_ready", 32'(upd_ready), 32'd0);
      check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      check("rst_mispredict", 32'(mispredict), 32'd0);
      repeat (2) step();
      reset = 1'b1;
      repeat (N + 2) step();
      do_fetch(8'h11);
      rand_cycles(500);
      repeat (5) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
